speed_tick_gen: RTL and testbench
=================================

SPEED_TICK_GEN -- requirements
Module: speed_tick_gen

Interface
REQ-001 Parameter CNT_W, default 32: width of the period register and the divider counter.
REQ-002 Parameter DEFAULT_PERIOD, default 4544: period loaded at reset and on restore.
REQ-003 Parameter STEP, default 20: amount added or subtracted per accepted request.
REQ-004 Parameter MIN_PERIOD, default 1000: lower saturation bound. MIN_PERIOD >= 2 and MIN_PERIOD <= DEFAULT_PERIOD.
REQ-005 Parameter MAX_PERIOD, default 20000: upper saturation bound. DEFAULT_PERIOD <= MAX_PERIOD < 2^CNT_W - STEP.
REQ-006 clk  input  1  single system clock; all state updates on the rising edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 faster  input  1  level request to shorten the period; acted on at its rising edge only.
REQ-009 slower  input  1  level request to lengthen the period; acted on at its rising edge only.
REQ-010 restore  input  1  level request to reload DEFAULT_PERIOD; acted on while high.
REQ-011 enable  input  1  divider run enable.
REQ-012 period  output  CNT_W  current period register.
REQ-013 tick  output  1  one-cycle strobe emitted once per period cycles.
REQ-014 at_min  output  1  high when period == MIN_PERIOD.
REQ-015 at_max  output  1  high when period == MAX_PERIOD.

Function
REQ-016 Registered copies of faster and slower are kept; a rise is the input high this cycle with its registered copy low.
REQ-017 Priority per cycle: restore, then a faster rise alone, then a slower rise alone. Simultaneous faster and slower rises leave the period unchanged.
REQ-018 Restore sets period to DEFAULT_PERIOD on the next edge and masks any faster or slower rise in the same cycle.
REQ-019 A faster rise sets period to max(period - STEP, MIN_PERIOD), computed one bit wider than CNT_W so there is no underflow.
REQ-020 A slower rise sets period to min(period + STEP, MAX_PERIOD), computed one bit wider than CNT_W so there is no overflow.
REQ-021 A held faster or slower level produces exactly one step. A new step needs the input to go low for at least one cycle and then rise again.
REQ-022 Divider: a down-counter div_cnt. When enable is high and div_cnt == 1, tick is high for that cycle and div_cnt reloads from period. Otherwise, when enable is high, div_cnt decrements.
REQ-023 A period change never truncates the current interval. The new value takes effect at the next reload.
REQ-024 When enable is low, div_cnt holds and tick is 0. Re-enabling resumes from the held count.
REQ-025 tick is registered; with enable held high and period constant P, ticks are exactly P cycles apart.
REQ-026 at_min and at_max are registered and update on the same edge as period.
REQ-027 period is always within [MIN_PERIOD, MAX_PERIOD].

Reset
REQ-028 While reset_n is low at a rising edge, the following are set regardless of all other inputs:
- period = DEFAULT_PERIOD
- div_cnt = DEFAULT_PERIOD
- tick = 0
- both edge registers = 0
- at_min and at_max set to reflect DEFAULT_PERIOD
REQ-029 Reset asserted mid-interval abandons the interval. The first tick after release comes DEFAULT_PERIOD cycles after the first enabled edge.
REQ-030 A faster or slower input already high when reset releases counts as a rise on the first edge after release, because its edge register was cleared.

Verification
REQ-031 Reset, enable=1, defaults -> tick every 4544 cycles, period = 4544, at_min = at_max = 0.
REQ-032 Hold faster for 50 cycles -> period = 4524, exactly one step; pulse faster 3 more times -> period = 4464.
REQ-033 Saturation, MIN_PERIOD = 4530: two faster pulses -> period = 4530, at_min = 1; a further pulse leaves it at 4530. Likewise at the MAX_PERIOD bound.
REQ-034 faster and slower rise on the same cycle -> period unchanged. restore together with a faster rise -> period = 4544.
REQ-035 Period changed from 4544 to 4564 mid-interval -> current gap stays 4544 cycles, next gap is 4564. Deasserting enable for 10 cycles lengthens that gap to exactly 4574.
REQ-036 reset_n pulsed low for 1 cycle mid-interval with period = 4464 -> period = 4544 and the next tick comes 4544 cycles after release.

Source files
------------

// File: rtl/speed_tick_gen_if.sv
// Request/status bundle for speed_tick_gen.
// The master side drives the speed requests and the run enable.
// The slave side (the generator) returns the period and its status.
interface speed_tick_gen_if #(
  parameter int CNT_W = 32
);
  logic             faster;
  logic             slower;
  logic             restore;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic             tick;
  logic             at_min;
  logic             at_max;

  modport master (
    output faster, slower, restore, enable,
    input  period, tick, at_min, at_max
  );

  modport slave (
    input  faster, slower, restore, enable,
    output period, tick, at_min, at_max
  );
endinterface

// File: rtl/speed_tick_gen.sv
// Programmable tick divider with a saturating, step-adjustable period.
// faster/slower nudge the period by STEP on their rising edges, and restore
// reloads the default. The divider counts down from the period and strobes
// tick once per interval. A period change only takes effect at the next
// reload, so the interval already in progress is never cut short.
module speed_tick_gen #(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 4544,
  parameter int STEP           = 20,
  parameter int MIN_PERIOD     = 1000,
  parameter int MAX_PERIOD     = 20000
) (
  input  logic             clk,
  input  logic             reset_n,
  speed_tick_gen_if.slave  bus
);
  localparam logic [CNT_W-1:0] DEF_P  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(STEP);
  localparam logic [CNT_W:0]   MIN_W  = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             faster_q, slower_q;
  logic             faster_rise, slower_rise;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic             tick_q, at_min_q, at_max_q;
  logic [CNT_W:0]   dec_w, inc_w;

  // Next period: restore wins, then a lone faster rise, then a lone slower
  // rise. Arithmetic is one bit wider so the clamps see true results.
  always_comb begin
    faster_rise = bus.faster & ~faster_q;
    slower_rise = bus.slower & ~slower_q;
    dec_w       = {1'b0, period_q} - STEP_W;
    inc_w       = {1'b0, period_q} + STEP_W;
    period_nxt  = period_q;
    if (bus.restore) begin
      period_nxt = DEF_P;
    end else if (faster_rise && !slower_rise) begin
      // A set MSB means the subtraction borrowed: clamp to the floor.
      period_nxt = (dec_w[CNT_W] || (dec_w < MIN_W)) ? MIN_P : dec_w[CNT_W-1:0];
    end else if (slower_rise && !faster_rise) begin
      period_nxt = (inc_w > MAX_W) ? MAX_P : inc_w[CNT_W-1:0];
    end
  end

  // Period register, its bound flags and the request edge detectors.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_q <= DEF_P;
      at_min_q <= (DEF_P == MIN_P);
      at_max_q <= (DEF_P == MAX_P);
      faster_q <= 1'b0;
      slower_q <= 1'b0;
    end else begin
      period_q <= period_nxt;
      at_min_q <= (period_nxt == MIN_P);
      at_max_q <= (period_nxt == MAX_P);
      faster_q <= bus.faster;
      slower_q <= bus.slower;
    end
  end

  // Divider: count down while enabled, strobe and reload on reaching one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= DEF_P;
      tick_q  <= 1'b0;
    end else if (bus.enable) begin
      if (div_cnt == ONE) begin
        div_cnt <= period_q;
        tick_q  <= 1'b1;
      end else begin
        div_cnt <= div_cnt - ONE;
        tick_q  <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign bus.period = period_q;
  assign bus.tick   = tick_q;
  assign bus.at_min = at_min_q;
  assign bus.at_max = at_max_q;
endmodule

// File: tb/tb_speed_tick_gen.sv
// Bench for speed_tick_gen. Two instances share one stimulus stream: dut0
// uses the default bounds, and dut1 uses tight bounds (4530..4580) so that
// saturation is reached in a few steps. An event-level model (elapsed
// enabled edges against the interval latched at the last tick) tracks each
// instance and is compared on every falling edge.
module tb_speed_tick_gen;
  localparam int  CNT_W = 32;
  localparam longint DEF  = 4544;
  localparam longint STEP = 20;
  localparam longint MIN0 = 1000,  MAX0 = 20000;
  localparam longint MIN1 = 4530,  MAX1 = 4580;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic faster = 1'b0, slower = 1'b0, restore = 1'b0, enable = 1'b0;

  speed_tick_gen_if #(.CNT_W(CNT_W)) if0 ();
  speed_tick_gen_if #(.CNT_W(CNT_W)) if1 ();

  assign if0.faster = faster;  assign if1.faster = faster;
  assign if0.slower = slower;  assign if1.slower = slower;
  assign if0.restore = restore; assign if1.restore = restore;
  assign if0.enable = enable;  assign if1.enable = enable;

  speed_tick_gen #(.CNT_W(CNT_W)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  speed_tick_gen #(.CNT_W(CNT_W), .MIN_PERIOD(4530), .MAX_PERIOD(4580))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  always #5 clk = ~clk;

  typedef struct {
    longint period;
    bit     fprev, sprev;
    longint elapsed, interval;
    bit     tick;
  } mdl_t;

  mdl_t   m0, m1;
  int     n_pass = 0, n_total = 0;
  bit     chk_en = 1'b0;
  longint cyc = 0;

  // One clock edge of the reference behaviour.
  function automatic mdl_t mstep(mdl_t m, bit rn, bit f, bit s, bit r, bit en,
                                 longint mn, longint mx);
    mdl_t n = m;
    bit fr, sr;
    if (!rn) begin
      n.period = DEF; n.fprev = 0; n.sprev = 0;
      n.elapsed = 0; n.interval = DEF; n.tick = 0;
      return n;
    end
    fr = f && !m.fprev;
    sr = s && !m.sprev;
    n.tick = 0;
    if (en) begin
      n.elapsed = m.elapsed + 1;
      if (n.elapsed == m.interval) begin
        n.tick = 1; n.elapsed = 0; n.interval = m.period;
      end
    end
    if (r)              n.period = DEF;
    else if (fr && !sr) n.period = (m.period - STEP < mn) ? mn : m.period - STEP;
    else if (sr && !fr) n.period = (m.period + STEP > mx) ? mx : m.period + STEP;
    n.fprev = f; n.sprev = s;
    return n;
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Advance both models on every rising edge.
  always @(posedge clk) begin
    cyc++;
    m0 = mstep(m0, reset_n, faster, slower, restore, enable, MIN0, MAX0);
    m1 = mstep(m1, reset_n, faster, slower, restore, enable, MIN1, MAX1);
  end

  // Compare DUT outputs with the models on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0.period", if0.period, m0.period);
      check("dut0.tick",   if0.tick,   m0.tick);
      check("dut0.at_min", if0.at_min, m0.period == MIN0);
      check("dut0.at_max", if0.at_max, m0.period == MAX0);
      check("dut1.period", if1.period, m1.period);
      check("dut1.tick",   if1.tick,   m1.tick);
      check("dut1.at_min", if1.at_min, m1.period == MIN1);
      check("dut1.at_max", if1.at_max, m1.period == MAX1);
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_f();
    faster = 1; cycles(2); faster = 0; cycles(2);
  endtask

  task automatic pulse_s();
    slower = 1; cycles(2); slower = 0; cycles(2);
  endtask

  // Wait for a dut0 tick with a bounded budget; returns its cycle stamp.
  task automatic wait_tick(output longint t);
    int k = 0;
    do begin
      @(negedge clk); k++;
    end while (!if0.tick && k < 6000);
    if (!if0.tick) begin
      n_total++;
      $display("FAIL wait_tick: no tick within %0d cycles (cycle %0d)", k, cyc);
    end
    t = cyc;
  endtask

  initial begin
    longint t0, t1, t2, t3;
    int k;
    // Reset state
    cycles(3);
    chk_en = 1'b1;
    check("reset period", if0.period, 4544);
    check("reset tick",   if0.tick,   0);
    check("reset at_min", if0.at_min, 0);
    check("reset at_max", if0.at_max, 0);
    reset_n = 1;

    // Free-running at the default period
    enable = 1;
    wait_tick(t0);
    wait_tick(t1);
    check("default gap", t1 - t0, 4544);

    // Held faster is one step; three more pulses
    faster = 1; cycles(50); faster = 0; cycles(2);
    check("held faster", if0.period, 4524);
    repeat (3) pulse_f();
    check("three pulses", if0.period, 4464);
    check("dut1 floor", if1.period, 4530);
    check("dut1 at_min", if1.at_min, 1);

    // Restore, simultaneous rises, restore masking faster
    restore = 1; cycles(1); restore = 0; cycles(1);
    check("restore", if0.period, 4544);
    faster = 1; slower = 1; cycles(2); faster = 0; slower = 0; cycles(2);
    check("both rise", if0.period, 4544);
    pulse_s();
    restore = 1; faster = 1; cycles(1); restore = 0; cycles(1); faster = 0; cycles(2);
    check("restore+faster", if0.period, 4544);

    // Upper saturation on dut1
    repeat (4) pulse_s();
    check("dut0 up", if0.period, 4624);
    check("dut1 ceiling", if1.period, 4580);
    check("dut1 at_max", if1.at_max, 1);

    // Mid-interval change and enable gap
    restore = 1; cycles(1); restore = 0;
    wait_tick(t0);
    cycles(1000);
    pulse_s();
    wait_tick(t1);
    check("gap before reload", t1 - t0, 4544);
    wait_tick(t2);
    check("gap after reload", t2 - t1, 4564);
    cycles(1000);
    enable = 0; cycles(10); enable = 1;
    wait_tick(t3);
    check("gap with pause", t3 - t2, 4574);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 199) != 0);
      restore = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) faster = ~faster;
      if ($urandom_range(0, 7) == 0) slower = ~slower;
      enable  = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk);
    reset_n = 1; restore = 1; faster = 0; slower = 0; enable = 1;
    cycles(1); restore = 0; cycles(2);

    // Reset pulse mid-interval
    repeat (4) pulse_f();
    check("pre-reset period", if0.period, 4464);
    cycles(500);
    reset_n = 0; cycles(1); reset_n = 1;
    check("post-reset period", if0.period, 4544);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!if0.tick && k < 6000);
    check("first tick after reset", k, 4544);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
